mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequencer between the CPU MEM stage and the word-wide data memory wrapper; drives cs/we/addr/data, waits for ack.
//  Performs byte/halfword stores as read-modify-write (memory writes whole words only).
//  Sign- or zero-extends load results and stalls the pipeline until each access completes.
//  Times out a missing ack as a bus error.
// PARAMETERS
//  ACK_TIMEOUT  16  cycles cs may stay high without ack before bus_err (>=2)
// PORTS
//  clock         in   1   system clock; all state updates on posedge
//  cpu_rst       in   1   synchronous, active-high reset
//  req_valid     in   1   MEM-stage access request; held high until done
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  req_unsigned  in   1   loads: 1 = zero-extend, 0 = sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned
//  stall         out  1   freeze pipeline while access in flight
//  done          out  1   one-cycle pulse: access finished
//  rdata         out  32  extended load result; valid while done=1
//  bus_err       out  1   one-cycle pulse with done: ack timeout
//  misalign      out  1   one-cycle pulse with done (MISALIGN_TRAP_EN only; tied 0 otherwise)
//  mem_cs        out  1   memory chip select
//  mem_we        out  1   memory write enable (only with mem_cs)
//  mem_addr      out  32  {addr[31:2],2'b00}
//  mem_wdata     out  32  full (merged) word to write
//  mem_ack       in   1   memory acknowledge
//  mem_rdata     in   32  memory read word; valid in cycle mem_ack sampled high
// BEHAVIOUR
//  Reset: state IDLE; stall, done, bus_err, misalign, mem_cs, mem_we = 0; rdata, mem_wdata, timeout counter = 0.
//  Reset mid-operation: abandons access at next posedge, mem_cs drops, no done pulse.
//  stall = req_valid & (state != DONE), combinational.
//  FSM:
//   IDLE:   req_valid -> latch req_* and go to the next state:
//           - load or sub-word store: go to RD
//           - word store: go to WR
//           Later req_* changes are ignored until DONE.
//   RD:     mem_cs=1, mem_we=0; on mem_ack capture mem_rdata.
//           - load: go to DONE
//           - sub-word store: go to GAP
//   GAP:    mem_cs=0 for one cycle; guarantees ack low before the next select. Go to WR.
//   WR:     mem_cs=1, mem_we=1, mem_wdata=merged word; on mem_ack go to DONE.
//   DONE:   done=1, cs=0 for one cycle; go to IDLE. Back-to-back request re-accepted the following cycle.
//  Merge:
//   - byte: lane addr[1:0] replaced by wdata[7:0]
//   - half: lanes {addr[1],0}..+1 replaced by wdata[15:0]
//  Load extract: same lane selection; extend to 32 bits per req_unsigned. Word: rdata = mem_rdata.
//  Timeout: counter clears on entering RD/WR and increments each cycle without ack.
//   - at ACK_TIMEOUT: go to DONE with bus_err=1, rdata=0; no write issued after a failed RD.
//  Minimum latency (ack on first cycle): load 2 cycles req->done; word store 2; sub-word store 4.
// CONFIGURATION
//  MISALIGN_TRAP_EN undefined:
//   - half ignores addr[0]; word ignores addr[1:0]
//   - access proceeds aligned down
//  MISALIGN_TRAP_EN defined:
//   - misaligned half (addr[0]=1) or word (addr[1:0]!=0): IDLE -> DONE directly
//   - misalign=1, rdata=0, mem_cs never asserted
// TESTING
//  1 Word load @0x10, mem_rdata=0xDEADBEEF, ack next cycle -> rdata=0xDEADBEEF, done 2 cycles after req, cs never has we.
//  2 Signed byte load @0x13, word=0x80112233 -> rdata=0xFFFFFF80; unsigned -> 0x00000080.
//  3 Half store 0xABCD @0x22, old word 0x11223344 -> RD, GAP (cs=0), WR mem_wdata=0xABCD3344, done at cycle 4.
//  4 ack held low, ACK_TIMEOUT=16 -> bus_err & done pulse 16 cycles after cs rise, cs drops, no WR.
//  5 cpu_rst pulsed during WR -> mem_cs/mem_we 0 next cycle, no done; new request then completes normally.
//  6 MISALIGN_TRAP_EN: word load @0x06 -> misalign=1, done next cycle, mem_cs stays 0; undefined -> reads 0x04.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundles the CPU MEM-stage request/response signals and the word-wide data
// memory bus that mem_access_ctrl sits between.
//
// Signals
//   CPU request   : req_valid, req_we, req_size[1:0], req_unsigned,
//                   req_addr[31:0], req_wdata[31:0]
//   CPU response  : stall, done, rdata[31:0], bus_err, misalign
//   Memory bus    : mem_cs, mem_we, mem_addr[31:0], mem_wdata[31:0] (to memory)
//                   mem_ack, mem_rdata[31:0]                        (from memory)
//
// Modports
//   master : the access controller (drives the memory bus and the response)
//   slave  : the environment (CPU stage + memory wrapper)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        bus_err;
    logic        misalign;

    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output stall, done, rdata, bus_err, misalign,
        output mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  stall, done, rdata, bus_err, misalign,
        input  mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Sequencer between the CPU MEM stage and a word-wide data memory.
//   - Loads: one read cycle, result lane-extracted and sign/zero extended.
//   - Word stores: one write cycle.
//   - Byte/half stores: read, one idle gap cycle, merged full-word write.
//   - A select held for ACK_TIMEOUT cycles without ack ends the access with
//     bus_err; a failed read of a read-modify-write never issues the write.
//   - The pipeline is stalled while a request is in flight.
//
// Ports
//   clock   : system clock, all state on posedge
//   cpu_rst : synchronous active-high reset
//   bus     : mem_access_ctrl_if.master (request, response, memory bus)
//
// Parameters
//   ACK_TIMEOUT : cycles the select may stay high without ack (>= 2)
//
// Configuration macro
//   MISALIGN_TRAP_EN : when defined, misaligned half/word requests complete
//                      immediately with misalign=1 and never select memory.
//                      When undefined, low address bits are ignored and the
//                      access proceeds aligned down; misalign stays 0.
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              cpu_rst,
    mem_access_ctrl_if.master bus
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Replace the addressed byte/half lane of old_word with store data.
    function automatic logic [31:0] merge_word(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = old_word;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    res[7:0]   = wdata[7:0];
                    2'd1:    res[15:8]  = wdata[7:0];
                    2'd2:    res[23:16] = wdata[7:0];
                    2'd3:    res[31:24] = wdata[7:0];
                    default: res        = old_word;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    res[31:16] = wdata[15:0];
                end else begin
                    res[15:0]  = wdata[15:0];
                end
            end
            default: res = wdata;
        endcase
        return res;
    endfunction

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        is_unsigned
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   res = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef MISALIGN_TRAP_EN
    // Half needs addr[0]=0, word (and size 11) needs addr[1:0]=0; bytes always fit.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic res;
        case (size)
            2'b00:   res = 1'b0;
            2'b01:   res = lane[0];
            default: res = (lane != 2'd0);
        endcase
        return res;
    endfunction
`endif

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;

    // Request fields held stable for the whole access.
    logic             we_r;
    logic [1:0]       size_r;
    logic             uns_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;

    logic             done_r;
    logic             bus_err_r;
    logic             misalign_r;
    logic [31:0]      rdata_r;
    logic             mem_cs_r;
    logic             mem_we_r;
    logic [31:0]      mem_wdata_r;

    logic             accept_s;
    logic             load_ack_s;
    logic             merge_ack_s;
    logic             timeout_s;
    logic             misalign_s;
    logic             misalign_req_s;
    logic             req_is_word_s;

    assign req_is_word_s = bus.req_size[1];

`ifdef MISALIGN_TRAP_EN
    assign misalign_req_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
    assign misalign_req_s = 1'b0;
`endif

    // Next-state and event decode for the access sequencer.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        load_ack_s   = 1'b0;
        merge_ack_s  = 1'b0;
        timeout_s    = 1'b0;
        misalign_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s   = 1'b1;
                    cnt_next_s = '0;
                    if (misalign_req_s) begin
                        misalign_s   = 1'b1;
                        next_state_s = ST_DONE;
                    end else if (bus.req_we && req_is_word_s) begin
                        next_state_s = ST_WR;
                    end else begin
                        next_state_s = ST_RD;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (bus.mem_ack) begin
                    if (we_r) begin
                        merge_ack_s  = 1'b1;
                        next_state_s = ST_GAP;
                    end else begin
                        load_ack_s   = 1'b1;
                        next_state_s = ST_DONE;
                    end
                end else if (cnt_r == TO_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                    next_state_s = ST_RD;
                end
            end
            ST_GAP: begin
                // Select is low here so the read ack is gone before the write.
                cnt_next_s   = '0;
                next_state_s = ST_WR;
            end
            ST_WR: begin
                if (bus.mem_ack) begin
                    next_state_s = ST_DONE;
                end else if (cnt_r == TO_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    cnt_next_s   = cnt_r + CNT_W'(1);
                    next_state_s = ST_WR;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and ack timeout counter.
    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Capture the request when it is accepted; ignore later changes.
    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            we_r    <= 1'b0;
            size_r  <= 2'b00;
            uns_r   <= 1'b0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            we_r    <= bus.req_we;
            size_r  <= bus.req_size;
            uns_r   <= bus.req_unsigned;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
        end else begin
            we_r    <= we_r;
            size_r  <= size_r;
            uns_r   <= uns_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Memory strobes and completion pulses, decoded from the next state so
    // they line up exactly with the state they belong to.
    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            mem_cs_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            done_r     <= 1'b0;
            bus_err_r  <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            mem_cs_r   <= (next_state_s == ST_RD) || (next_state_s == ST_WR);
            mem_we_r   <= (next_state_s == ST_WR);
            done_r     <= (next_state_s == ST_DONE);
            bus_err_r  <= timeout_s;
            misalign_r <= misalign_s;
        end
    end

    // Load result: extended read data, or zero for an aborted access.
    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            rdata_r <= 32'd0;
        end else if (load_ack_s) begin
            rdata_r <= extract_load(bus.mem_rdata, size_r, addr_r[1:0], uns_r);
        end else if (timeout_s || misalign_s) begin
            rdata_r <= 32'd0;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Write word: store data directly for word stores, merged with the old
    // word (taken straight from the read ack) for sub-word stores.
    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            mem_wdata_r <= 32'd0;
        end else if (accept_s && (next_state_s == ST_WR)) begin
            mem_wdata_r <= bus.req_wdata;
        end else if (merge_ack_s) begin
            mem_wdata_r <= merge_word(bus.mem_rdata, wdata_r, size_r, addr_r[1:0]);
        end else begin
            mem_wdata_r <= mem_wdata_r;
        end
    end

    assign bus.stall     = bus.req_valid & (state_r != ST_DONE);
    assign bus.done      = done_r;
    assign bus.bus_err   = bus_err_r;
    assign bus.misalign  = misalign_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_cs    = mem_cs_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = {addr_r[31:2], 2'b00};
    assign bus.mem_wdata = mem_wdata_r;

endmodule
